pl_stage_sequencer: RTL

Controller that sequences the NewHope pipeline stages (stage 0 … stage NUM_STAGES-1) as a lock-step, slot-synchronous pipeline. It accepts new jobs through a valid/ready handshake and issues one-cycle `start_stage` pulses to every occupied stage. It then waits for each occupied stage's `done_stage` pulse and advances all jobs one stage together. It sits above the `pl_stage_N` instances and owns all of their start signals.

---
 rtl/pl_ctrl_pkg.sv | 15 +
 rtl/pl_stage_sequencer_if.sv | 28 ++
 rtl/pl_timeout_counter.sv | 36 +++
 rtl/pl_stage_sequencer.sv | 106 ++++++++++
 4 files changed

// File: rtl/pl_ctrl_pkg.sv
// Shared types and defaults for the pipeline stage sequencer.
package pl_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLaunch  = 2'd1,
        StWait    = 2'd2,
        StAdvance = 2'd3
    } state_e;

    localparam int unsigned DefNumStages = 7;
    localparam int unsigned DefTimeout   = 4096;
    localparam int unsigned DefToW       = 13;

endpackage

// File: rtl/pl_stage_sequencer_if.sv
// Job handshake and per-stage start/done bundle of the stage sequencer.
interface pl_stage_sequencer_if
    import pl_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DefNumStages
);

    logic                  job_valid;
    logic                  job_ready;
    logic [NUM_STAGES-1:0] start_stage;
    logic [NUM_STAGES-1:0] done_stage;
    logic                  job_done;
    logic [NUM_STAGES-1:0] occupancy;
    logic                  busy;
    logic                  timeout_err;

    // master: the sequencer; slave: job source plus the stage instances
    modport master (
        input  job_valid, done_stage,
        output job_ready, start_stage, job_done, occupancy, busy, timeout_err
    );

    modport slave (
        output job_valid, done_stage,
        input  job_ready, start_stage, job_done, occupancy, busy, timeout_err
    );

endinterface

// File: rtl/pl_timeout_counter.sv
// WAIT-phase watchdog counter; expired flags the last allowed cycle. limit==0 disables it.
module pl_timeout_counter
    import pl_ctrl_pkg::*;
#(
    parameter int unsigned TO_W = DefToW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            count_en,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (clear) begin
            tcnt_d = '0;
        end else if (count_en) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign expired = (limit != '0) && (tcnt_q == limit - 1'b1);

endmodule

// File: rtl/pl_stage_sequencer.sv
// Lock-step sequencer: launches every occupied stage, waits for all dones, then shifts jobs
// one stage along, admitting a new job into stage 0 on the advance cycle.
module pl_stage_sequencer
    import pl_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DefNumStages,
    parameter int unsigned TIMEOUT    = DefTimeout,
    parameter int unsigned TO_W       = DefToW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    pl_stage_sequencer_if.master bus
);

    localparam logic [TO_W-1:0] Limit = TO_W'(TIMEOUT);

    state_e                state_q, state_d;
    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [NUM_STAGES-1:0] pend_q, pend_d;
    logic [NUM_STAGES-1:0] pend_left;
    logic                  err_q, err_d;
    logic                  job_ready;
    logic                  accept;
    logic                  expired;

    assign job_ready = rst & en & ~err_q & ((state_q == StIdle) | (state_q == StAdvance));
    assign accept    = bus.job_valid & job_ready;
    // Dones are folded in even while en is low so a pulse during a stall is never lost.
    assign pend_left = pend_q & ~bus.done_stage;

    pl_timeout_counter #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == StLaunch),
        .count_en ((state_q == StWait) & en),
        .limit    (Limit),
        .expired  (expired)
    );

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        pend_d  = pend_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    v_d     = NUM_STAGES'(1);
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                if (en) begin
                    pend_d  = v_q;
                    state_d = StWait;
                end
            end
            StWait: begin
                pend_d = pend_left;
                if (en) begin
                    if (pend_left == '0) begin
                        state_d = StAdvance;
                    end else if (expired) begin
                        err_d   = 1'b1;
                        v_d     = '0;
                        pend_d  = '0;
                        state_d = StIdle;
                    end
                end
            end
            StAdvance: begin
                if (en) begin
                    v_d     = {v_q[NUM_STAGES-2:0], accept};
                    state_d = (v_d != '0) ? StLaunch : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            v_q     <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // en qualifies the pulses so a frozen LAUNCH/ADVANCE emits exactly one pulse on release.
    assign bus.start_stage = (state_q == StLaunch && en) ? v_q : '0;
    assign bus.job_done    = (state_q == StAdvance) && en && v_q[NUM_STAGES-1];
    assign bus.job_ready   = job_ready;
    assign bus.occupancy   = v_q;
    assign bus.busy        = |v_q;
    assign bus.timeout_err = err_q;

endmodule
